// File: rtl/truth_table_checker.sv
// truth_table_checker
// Walks every input vector of an NIN-input combinational cell in ascending
// order, holds each vector SETTLE cycles, samples the cell output once, and
// compares it to the EXPECTED truth table.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a run (ignored while busy)
//   dut_out    output of the cell under test
//   vec_out    vector driven to the cell (bit NIN-1 = first cell input)
//   busy       run in progress
//   done       run complete, results valid until the next start
//   pass       done with zero mismatches
//   err_count  number of mismatching vectors
//   fail_map   bit i set if vector i mismatched
//   sampled    bit i is the captured cell output for vector i
//
// state  | meaning
// IDLE   | waiting for start, no results
// APPLY  | vector idx driven, settle counter running
// SAMPLE | one-cycle capture and compare of vector idx
// DONE   | results held, waiting for start
module truth_table_checker #(
    parameter int                  NIN      = 3,
    parameter int                  SETTLE   = 4,
    parameter logic [2**NIN-1:0]   EXPECTED = 8'b1110_1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 dut_out,
    output logic [NIN-1:0]       vec_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [NIN:0]         err_count,
    output logic [2**NIN-1:0]    fail_map,
    output logic [2**NIN-1:0]    sampled
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] APPLY  = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [1:0]          state_q, state_d;
    logic [NIN-1:0]      idx_q, idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NIN:0]        err_count_q, err_count_d;
    logic [2**NIN-1:0]   fail_map_q, fail_map_d;
    logic [2**NIN-1:0]   sampled_q, sampled_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        err_count_d = err_count_q;
        fail_map_d  = fail_map_q;
        sampled_d   = sampled_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = APPLY;
                    idx_d       = '0;
                    cnt_d       = '0;
                    err_count_d = '0;
                    fail_map_d  = '0;
                    sampled_d   = '0;
                end
            end
            APPLY: begin
                if (cnt_q == CW'(SETTLE - 1)) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            SAMPLE: begin
                sampled_d[idx_q] = dut_out;
                // Case-inequality so an X/Z cell output is a mismatch.
                if (dut_out !== EXPECTED[idx_q]) begin
                    fail_map_d[idx_q] = 1'b1;
                    err_count_d       = err_count_q + (NIN+1)'(1);
                end
                if (idx_q == {NIN{1'b1}}) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + NIN'(1);
                    cnt_d   = '0;
                    state_d = APPLY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            err_count_q <= '0;
            fail_map_q  <= '0;
            sampled_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            err_count_q <= err_count_d;
            fail_map_q  <= fail_map_d;
            sampled_q   <= sampled_d;
        end
    end

    // idx_q is itself the driven vector; it stays on the last vector in DONE.
    assign vec_out   = idx_q;
    assign busy      = (state_q == APPLY) || (state_q == SAMPLE);
    assign done      = (state_q == DONE);
    assign pass      = (state_q == DONE) && (err_count_q == '0);
    assign err_count = err_count_q;
    assign fail_map  = fail_map_q;
    assign sampled   = sampled_q;

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a, start_b;
    logic [1:0] mode;
    logic       dut_out_a, dut_out_b;

    logic [2:0] vec_a;
    logic       busy_a, done_a, pass_a;
    logic [3:0] err_a;
    logic [7:0] fail_a, samp_a;

    logic [1:0] vec_b;
    logic       busy_b, done_b, pass_b;
    logic [2:0] err_b;
    logic [3:0] fail_b, samp_b;

    int checks = 0;
    int errors = 0;

    truth_table_checker u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .dut_out(dut_out_a),
        .vec_out(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .fail_map(fail_a), .sampled(samp_a)
    );

    truth_table_checker #(.NIN(2), .SETTLE(1), .EXPECTED(4'b0110)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .dut_out(dut_out_b),
        .vec_out(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .fail_map(fail_b), .sampled(samp_b)
    );

    // mode 0: majority, 1: inverted majority, 2: tied low
    logic maj;
    always_comb begin
        maj = (vec_a[2] & vec_a[1]) | (vec_a[1] & vec_a[0]) | (vec_a[2] & vec_a[0]);
        case (mode)
            2'd0:    dut_out_a = maj;
            2'd1:    dut_out_a = ~maj;
            default: dut_out_a = 1'b0;
        endcase
    end
    assign dut_out_b = vec_b[1] ^ vec_b[0];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic pulse_a();
        @(negedge clk) start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
    endtask

    // Counts edges after the start edge until done; re-pulses start at r1/r2.
    task automatic wait_done_a(input int r1, input int r2, output int cyc,
                               output int seq_bad, output int overlap);
        int exp_vec;
        cyc = 0; seq_bad = 0; overlap = 0;
        while (!done_a && cyc < 200) begin
            @(negedge clk);
            start_a = (cyc == r1 || cyc == r2) ? 1'b1 : 1'b0;
            @(posedge clk);
            #1;
            cyc++;
            start_a = 1'b0;
            if (busy_a && done_a) overlap = 1;
            exp_vec = (cyc / 5 > 7) ? 7 : cyc / 5;
            if (32'(vec_a) != 32'(exp_vec)) seq_bad = 1;
        end
    endtask

    int cyc, seq_bad, overlap;

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; mode = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vec",  32'(vec_a),  0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_pass", 32'(pass_a), 0);
        check("rst_err",  32'(err_a),  0);
        check("rst_fail", 32'(fail_a), 0);
        check("rst_samp", 32'(samp_a), 0);
        @(negedge clk) rst_n = 1'b1;

        // majority cell
        mode = 2'd0;
        pulse_a();
        check("maj_start_busy", 32'(busy_a), 1);
        check("maj_start_vec",  32'(vec_a),  0);
        check("maj_start_done", 32'(done_a), 0);
        wait_done_a(-1, -1, cyc, seq_bad, overlap);
        check("maj_cycles",  32'(cyc), 40);
        check("maj_seq",     32'(seq_bad), 0);
        check("maj_overlap", 32'(overlap), 0);
        check("maj_pass",    32'(pass_a), 1);
        check("maj_busy",    32'(busy_a), 0);
        check("maj_err",     32'(err_a), 0);
        check("maj_fail",    32'(fail_a), 32'h00);
        check("maj_samp",    32'(samp_a), 32'hE8);
        check("maj_lastvec", 32'(vec_a), 7);

        // inverted majority, start re-pulsed mid-run
        mode = 2'd1;
        pulse_a();
        wait_done_a(5, 17, cyc, seq_bad, overlap);
        check("inv_cycles", 32'(cyc), 40);
        check("inv_seq",    32'(seq_bad), 0);
        check("inv_err",    32'(err_a), 8);
        check("inv_fail",   32'(fail_a), 32'hFF);
        check("inv_samp",   32'(samp_a), 32'h17);
        check("inv_pass",   32'(pass_a), 0);
        check("inv_done",   32'(done_a), 1);

        // restart from DONE, tied-low cell
        mode = 2'd2;
        pulse_a();
        check("rs_done", 32'(done_a), 0);
        check("rs_pass", 32'(pass_a), 0);
        check("rs_busy", 32'(busy_a), 1);
        check("rs_vec",  32'(vec_a), 0);
        check("rs_err",  32'(err_a), 0);
        check("rs_fail", 32'(fail_a), 0);
        check("rs_samp", 32'(samp_a), 0);
        wait_done_a(-1, -1, cyc, seq_bad, overlap);
        check("t0_cycles", 32'(cyc), 40);
        check("t0_err",    32'(err_a), 4);
        check("t0_fail",   32'(fail_a), 32'hE8);
        check("t0_samp",   32'(samp_a), 32'h00);
        check("t0_pass",   32'(pass_a), 0);

        // asynchronous reset mid-run
        mode = 2'd0;
        pulse_a();
        repeat (12) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("ar_vec",  32'(vec_a), 0);
        check("ar_busy", 32'(busy_a), 0);
        check("ar_done", 32'(done_a), 0);
        check("ar_err",  32'(err_a), 0);
        check("ar_fail", 32'(fail_a), 0);
        check("ar_samp", 32'(samp_a), 0);
        @(negedge clk) rst_n = 1'b1;
        pulse_a();
        wait_done_a(-1, -1, cyc, seq_bad, overlap);
        check("ar_run_cycles", 32'(cyc), 40);
        check("ar_run_pass",   32'(pass_a), 1);
        check("ar_run_samp",   32'(samp_a), 32'hE8);

        // NIN=2, SETTLE=1 XOR cell
        @(negedge clk) start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        check("x_start_busy", 32'(busy_b), 1);
        cyc = 0; seq_bad = 0;
        while (!done_b && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (32'(vec_b) != 32'(((cyc / 2) > 3) ? 3 : (cyc / 2))) seq_bad = 1;
        end
        check("x_cycles", 32'(cyc), 8);
        check("x_seq",    32'(seq_bad), 0);
        check("x_pass",   32'(pass_b), 1);
        check("x_err",    32'(err_b), 0);
        check("x_fail",   32'(fail_b), 0);
        check("x_samp",   32'(samp_b), 32'h6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
